// File: rtl/raster_tile_sched.sv
// ---------------------------------------------------------------------------
// raster_tile_sched
//
// Raster tile scheduler. It latches the raster DCR state and walks the tile
// buffer in memory one 8-byte entry at a time. Each entry is handed to one of
// NUM_SLICES raster slices, and the slice is picked by round-robin
// arbitration. Each pass runs from a `start` pulse to a `done` pulse.
//
// Optional feature: define RASTER_SKIP_EMPTY_EN to drop entries whose
// prim_count is zero instead of dispatching them.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   dcr_write_*             DCR write bus (valid / addr / 32-bit data)
//   start, busy, done       pass control and status
//   mem_req_*               tile-entry read request (valid / ready / addr)
//   mem_rsp_*               tile-entry read response (valid / ready / data)
//                           data: [15:0] tile_x, [31:16] tile_y,
//                                 [63:32] prim_count
//   slice_valid             one-hot tile offer, combinational on slice_ready
//   slice_tile_x/_y         registered tile position, shared by all slices
//   slice_prim_count        registered primitive count
//   slice_pbuf_addr/_stride copies of the latched DCRs
//   slice_ready             per-slice accept
// ---------------------------------------------------------------------------
module raster_tile_sched #(
   parameter int NUM_SLICES    = 4,
   parameter int DCR_ADDR_BITS = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dcr_write_valid,
   input  logic [DCR_ADDR_BITS-1:0] dcr_write_addr,
   input  logic [31:0]              dcr_write_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_req_valid,
   output logic [31:0]              mem_req_addr,
   input  logic                     mem_req_ready,
   input  logic                     mem_rsp_valid,
   input  logic [63:0]              mem_rsp_data,
   output logic                     mem_rsp_ready,
   output logic [NUM_SLICES-1:0]    slice_valid,
   output logic [15:0]              slice_tile_x,
   output logic [15:0]              slice_tile_y,
   output logic [31:0]              slice_prim_count,
   output logic [31:0]              slice_pbuf_addr,
   output logic [31:0]              slice_pbuf_stride,
   input  logic [NUM_SLICES-1:0]    slice_ready
);

   localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_TBUF_ADDR   = DCR_ADDR_BITS'(16'h010);
   localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_TILE_COUNT  = DCR_ADDR_BITS'(16'h011);
   localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_PBUF_ADDR   = DCR_ADDR_BITS'(16'h012);
   localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_PBUF_STRIDE = DCR_ADDR_BITS'(16'h013);
   // DST_SIZE (0x014) lives on the same bus but is not used by this block.

   localparam int RR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_RSP,
      S_DISPATCH,
      S_DONE
   } state_t;

   state_t              state, state_next;
   logic [31:0]         tbuf_addr, tile_count, pbuf_addr, pbuf_stride;
   logic [31:0]         idx;
   logic [31:0]         req_addr;
   logic [RR_W-1:0]     rr_ptr;
   logic [NUM_SLICES-1:0] grant;
   logic [RR_W-1:0]     grant_idx;
   logic                grant_found;
   logic                handshake;
   logic                skip_entry;
   logic                last_entry;
   int                  j;

   // Round-robin pick: first ready slice at or above rr_ptr, wrapping.
   // NOTE: every variable written here gets a default first, so no path
   // leaves a value held and no latch is inferred.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      j           = 0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_SLICES) j = j - NUM_SLICES;
         if (!grant_found && slice_ready[j]) begin
            grant_found = 1'b1;
            grant[j]    = 1'b1;
            grant_idx   = RR_W'(j);
         end
      end
   end

   assign handshake  = (state == S_DISPATCH) && grant_found;
   assign last_entry = (idx == tile_count - 32'd1);

`ifdef RASTER_SKIP_EMPTY_EN
   assign skip_entry = (state == S_WAIT_RSP) && mem_rsp_valid &&
                       (mem_rsp_data[63:32] == 32'd0);
`else
   assign skip_entry = 1'b0;
`endif

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:
            if (start) state_next = (tile_count == 32'd0) ? S_DONE : S_FETCH;
         S_FETCH:
            if (mem_req_ready) state_next = S_WAIT_RSP;
         S_WAIT_RSP:
            if (mem_rsp_valid) begin
               if (skip_entry) state_next = last_entry ? S_DONE : S_FETCH;
               else            state_next = S_DISPATCH;
            end
         S_DISPATCH:
            if (grant_found) state_next = last_entry ? S_DONE : S_FETCH;
         S_DONE:
            state_next = S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         tbuf_addr        <= '0;
         tile_count       <= '0;
         pbuf_addr        <= '0;
         pbuf_stride      <= '0;
         idx              <= '0;
         req_addr         <= '0;
         rr_ptr           <= '0;
         slice_tile_x     <= '0;
         slice_tile_y     <= '0;
         slice_prim_count <= '0;
      end else begin
         state <= state_next;

         // The register file is frozen for the duration of a pass.
         if (dcr_write_valid && (state == S_IDLE)) begin
            if (dcr_write_addr == DCR_RASTER_TBUF_ADDR)   tbuf_addr   <= dcr_write_data;
            if (dcr_write_addr == DCR_RASTER_TILE_COUNT)  tile_count  <= dcr_write_data;
            if (dcr_write_addr == DCR_RASTER_PBUF_ADDR)   pbuf_addr   <= dcr_write_data;
            if (dcr_write_addr == DCR_RASTER_PBUF_STRIDE) pbuf_stride <= dcr_write_data;
         end

         // The request address is tracked incrementally next to idx, so
         // tbuf_addr + idx*8 never needs a multiplier. It wraps at 32 bits.
         if ((state == S_IDLE) && start) begin
            idx      <= '0;
            req_addr <= tbuf_addr;
         end else if (handshake || skip_entry) begin
            idx      <= idx + 32'd1;
            req_addr <= req_addr + 32'd8;
         end

         if ((state == S_WAIT_RSP) && mem_rsp_valid) begin
            slice_tile_x     <= mem_rsp_data[15:0];
            slice_tile_y     <= mem_rsp_data[31:16];
            slice_prim_count <= mem_rsp_data[63:32];
         end

         if (handshake)
            rr_ptr <= (grant_idx == RR_W'(NUM_SLICES - 1)) ? '0 : grant_idx + RR_W'(1);
      end
   end

   assign busy              = (state != S_IDLE);
   assign done              = (state == S_DONE);
   assign mem_req_valid     = (state == S_FETCH);
   assign mem_req_addr      = req_addr;
   assign mem_rsp_ready     = (state == S_WAIT_RSP);
   assign slice_valid       = (state == S_DISPATCH) ? grant : '0;
   assign slice_pbuf_addr   = pbuf_addr;
   assign slice_pbuf_stride = pbuf_stride;

endmodule

// File: tb/tb_raster_tile_sched.sv
// ---------------------------------------------------------------------------
// tb_raster_tile_sched
//
// Self-checking bench for raster_tile_sched. A behavioural model tracks what
// each pass must look like from the outside: the pass phase, the entry index,
// the round-robin pointer and the DCR values. Every cycle it predicts busy,
// done, the request/response handshake signals, the request address, the
// one-hot grant and the tile data. The model also plays the memory, with
// random latency, and the slices, with random or directed readiness.
// ---------------------------------------------------------------------------
module tb_raster_tile_sched;

   localparam int NS = 4;
   localparam int AW = 12;
   localparam logic [AW-1:0] A_TBUF   = 12'h010;
   localparam logic [AW-1:0] A_COUNT  = 12'h011;
   localparam logic [AW-1:0] A_PBUF   = 12'h012;
   localparam logic [AW-1:0] A_STRIDE = 12'h013;
   localparam logic [AW-1:0] A_DST    = 12'h014;
`ifdef RASTER_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef enum int {P_START, P_FETCH, P_RSP, P_DISP, P_DONE, P_END} phase_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          dcr_write_valid;
   logic [AW-1:0] dcr_write_addr;
   logic [31:0]   dcr_write_data;
   logic          start;
   logic          busy, done;
   logic          mem_req_valid, mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [63:0]   mem_rsp_data;
   logic [NS-1:0] slice_valid, slice_ready;
   logic [15:0]   slice_tile_x, slice_tile_y;
   logic [31:0]   slice_prim_count, slice_pbuf_addr, slice_pbuf_stride;

   raster_tile_sched #(.NUM_SLICES(NS), .DCR_ADDR_BITS(AW)) dut (
      .clk(clk), .reset(reset),
      .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
      .dcr_write_data(dcr_write_data),
      .start(start), .busy(busy), .done(done),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_ready(mem_rsp_ready),
      .slice_valid(slice_valid), .slice_tile_x(slice_tile_x),
      .slice_tile_y(slice_tile_y), .slice_prim_count(slice_prim_count),
      .slice_pbuf_addr(slice_pbuf_addr), .slice_pbuf_stride(slice_pbuf_stride),
      .slice_ready(slice_ready)
   );

   always #5 clk = ~clk;

   int n_errors = 0;
   int n_checks = 0;

   // Model state.
   logic [31:0] m_tbuf, m_count, m_pbuf, m_stride;
   int          m_rr;
   logic [63:0] ent [16];
   int          grants[$];
   int          n_disp;
   int          stall_cnt;
   int          done_cyc;
   logic [31:0] first_req_addr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] rr_grant(input logic [NS-1:0] rdy, input int ptr);
      logic [NS-1:0] one;
      one = 1;
      for (int i = 0; i < NS; i++) begin
         int k;
         k = (ptr + i) % NS;
         if (rdy[k]) return one << k;
      end
      return '0;
   endfunction

   function automatic int onehot_idx(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_tbuf = 0; m_count = 0; m_pbuf = 0; m_stride = 0; m_rr = 0;
   endtask

   task automatic dcr_write(input logic [AW-1:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      dcr_write_valid = 1'b1; dcr_write_addr = addr; dcr_write_data = data;
      @(posedge clk); #1;
      dcr_write_valid = 1'b0;
      case (addr)
         A_TBUF:   m_tbuf   = data;
         A_COUNT:  m_count  = data;
         A_PBUF:   m_pbuf   = data;
         A_STRIDE: m_stride = data;
         default: ;
      endcase
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   // mode 0: all slices ready, zero-latency memory, request always accepted
   // mode 1: random readiness, latency and request acceptance
   // mode 2: first tile sees only slice 2, second tile stalls 10 cycles
   task automatic run_pass(input int n, input int mode, input bit inject);
      phase_t        ph;
      int            idx, lat, cyc, wait_cyc;
      bit            got_first;
      logic [63:0]   cur;
      logic [NS-1:0] exp_g;
      logic [31:0]   exp_addr;
      ph = P_START; idx = 0; lat = 0; cyc = 0; wait_cyc = 0; got_first = 0;
      cur = '0; grants.delete(); n_disp = 0; stall_cnt = -1; done_cyc = -1;
      first_req_addr = '0;
      while (ph != P_END && cyc < 500) begin
         @(posedge clk); #1;
         start           = (cyc == 0) || (inject && cyc == 4);
         dcr_write_valid = inject && (cyc == 5 || cyc == 6);
         dcr_write_addr  = (cyc == 5) ? A_TBUF : A_PBUF;
         dcr_write_data  = 32'hDEAD_0000;
         mem_req_ready   = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         mem_rsp_valid   = 1'b0;
         mem_rsp_data    = {$urandom, $urandom};
         if (ph == P_RSP) begin
            if (lat == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = ent[idx];
            end else lat--;
         end
         case (mode)
            0: slice_ready = '1;
            1: slice_ready = NS'($urandom);
            default: slice_ready = (n_disp == 0) ? NS'(4'b0100) :
                                   (wait_cyc < 10) ? '0 : '1;
         endcase
         #1;
         exp_addr = m_tbuf + 32'(idx) * 32'd8;
         exp_g    = (ph == P_DISP) ? rr_grant(slice_ready, m_rr) : '0;
         check("busy", busy, ph != P_START);
         check("done", done, ph == P_DONE);
         check("req_valid", mem_req_valid, ph == P_FETCH);
         check("rsp_ready", mem_rsp_ready, ph == P_RSP);
         check("slice_valid", slice_valid, exp_g);
         if (ph == P_FETCH) begin
            check("req_addr", mem_req_addr, exp_addr);
            if (!got_first) begin first_req_addr = mem_req_addr; got_first = 1; end
         end
         if (ph == P_DISP) begin
            check("tile_x", slice_tile_x, cur[15:0]);
            check("tile_y", slice_tile_y, cur[31:16]);
            check("prim", slice_prim_count, cur[63:32]);
            check("pbuf_addr", slice_pbuf_addr, m_pbuf);
            check("pbuf_stride", slice_pbuf_stride, m_stride);
         end
         if (done) done_cyc = cyc;
         case (ph)
            P_START: ph = (n == 0) ? P_DONE : P_FETCH;
            P_FETCH: if (mem_req_ready) begin
               ph  = P_RSP;
               lat = (mode == 1) ? $urandom_range(0, 3) : 0;
            end
            P_RSP: if (mem_rsp_valid) begin
               cur = ent[idx];
               if (SKIP && cur[63:32] == 32'd0) begin
                  idx++;
                  ph = (idx == n) ? P_DONE : P_FETCH;
               end else begin
                  ph = P_DISP; wait_cyc = 0;
               end
            end
            P_DISP: if (exp_g != '0) begin
               grants.push_back(onehot_idx(exp_g));
               m_rr = (onehot_idx(exp_g) + 1) % NS;
               if (n_disp == 1) stall_cnt = wait_cyc;
               n_disp++; idx++;
               ph = (idx == n) ? P_DONE : P_FETCH;
            end else wait_cyc++;
            P_DONE: ph = P_END;
            default: ;
         endcase
         cyc++;
      end
      check("pass_finished", ph == P_END, 1'b1);
      @(posedge clk); #1;
      start = 1'b0; dcr_write_valid = 1'b0; mem_rsp_valid = 1'b0;
      #1;
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with pins driven to non-idle values.
      reset = 1'b0;
      dcr_write_valid = 1'b1; dcr_write_addr = A_TBUF; dcr_write_data = 32'hFFFF_FFFF;
      start = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
      mem_rsp_data = '1; slice_ready = '1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_rsp_ready", mem_rsp_ready, 1'b0);
      check("rst_slice_valid", slice_valid, '0);
      check("rst_req_addr", mem_req_addr, '0);
      check("rst_tile", {slice_tile_x, slice_tile_y, slice_prim_count}, '0);
      check("rst_pbuf", {slice_pbuf_addr, slice_pbuf_stride}, '0);
      dcr_write_valid = 1'b0; start = 1'b0; mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0; slice_ready = '0;
      reset = 1'b1;

      // Register map, including ignored addresses.
      dcr_write(A_TBUF, 32'h1000);
      dcr_write(A_COUNT, 3);
      dcr_write(A_PBUF, 32'hA000);
      dcr_write(A_STRIDE, 32'h40);
      dcr_write(A_DST, 32'h1234_5678);
      dcr_write(12'h7FF, 32'h5555_5555);
      #1;
      check("dcr_pbuf", slice_pbuf_addr, 32'hA000);
      check("dcr_stride", slice_pbuf_stride, 32'h40);

      // Three tiles, all ready, zero-latency memory.
      for (int i = 0; i < 3; i++) ent[i] = {32'(i + 5), 16'(i + 20), 16'(i + 10)};
      run_pass(3, 0, 0);
      check("first_addr", first_req_addr, 32'h1000);
      check("rr_count", grants.size(), 3);
      for (int i = 0; i < grants.size(); i++) check("rr_seq", grants[i], i);

      // Directed arbitration from rr_ptr=0 with a long stall.
      pulse_reset();
      dcr_write(A_TBUF, 32'h3000);
      dcr_write(A_COUNT, 2);
      run_pass(2, 2, 0);
      check("dir_count", grants.size(), 2);
      if (grants.size() == 2) begin
         check("dir_grant0", grants[0], 2);
         check("dir_grant1", grants[1], 3);
      end
      check("dir_stall", stall_cnt, 10);

      // Zero tiles: done on the next cycle, no request.
      dcr_write(A_COUNT, 0);
      run_pass(0, 0, 0);
      check("zero_done_cyc", done_cyc, 1);

      // Empty middle entry.
      dcr_write(A_COUNT, 3);
      ent[0] = {32'd7, 16'd1, 16'd2};
      ent[1] = {32'd0, 16'd3, 16'd4};
      ent[2] = {32'd9, 16'd5, 16'd6};
      run_pass(3, 1, 0);
      check("empty_dispatches", n_disp, SKIP ? 3'd2 : 3'd3);

      // DCR write and restart while busy are ignored.
      dcr_write(A_TBUF, 32'h2000);
      dcr_write(A_COUNT, 3);
      run_pass(3, 0, 1);
      check("busy_pbuf_kept", slice_pbuf_addr, m_pbuf);
      dcr_write(A_COUNT, 1);
      run_pass(1, 0, 0);
      check("busy_tbuf_kept", first_req_addr, 32'h2000);

      // Reset asserted while waiting for a response.
      dcr_write(A_TBUF, 32'h4000);
      dcr_write(A_COUNT, 2);
      begin
         bit seen;
         seen = 0;
         @(posedge clk); #1;
         start = 1'b1;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
            #1;
            seen = mem_req_valid;
         end
         check("mr_req_seen", seen, 1'b1);
         @(posedge clk); #1;
         check("mr_in_wait_rsp", mem_rsp_ready, 1'b1);
         reset = 1'b0;
         #1;
         check("mr_busy", busy, 1'b0);
         check("mr_rsp_ready", mem_rsp_ready, 1'b0);
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b1;
         model_reset();
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #2;
            check("mr_no_done", done, 1'b0);
            check("mr_idle", busy, 1'b0);
         end
         check("mr_dcr_cleared", slice_pbuf_addr, '0);
      end

      // Random passes, some starting near the top of the address space.
      dcr_write(A_PBUF, $urandom);
      dcr_write(A_STRIDE, $urandom);
      for (int p = 0; p < 12; p++) begin
         int n;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++)
            ent[i] = {($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom};
         dcr_write(A_TBUF, (p % 3 == 0) ? 32'hFFFF_FFE8 : ($urandom & 32'hFFFF_FFF8));
         dcr_write(A_COUNT, n);
         run_pass(n, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/raster_tile_sched.md
# raster_tile_sched

Raster tile scheduler: latches the raster DCR state, walks the tile buffer in memory one entry at a time, and hands each non-empty tile to one of NUM_SLICES raster slices using round-robin arbitration. Sits between the DCR bus / memory port and the raster slices, and sequences each tile-buffer pass from `start` to `done`.

## Interface
- NUM_SLICES, 4: raster slices served, 1..8.
- DCR_ADDR_BITS, 12: DCR address width.
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- dcr_write_valid  in  1  DCR write strobe.
- dcr_write_addr  in  DCR_ADDR_BITS  DCR write address.
- dcr_write_data  in  32  DCR write data.
- start  in  1  single-cycle pulse that begins a pass.
- busy  out  1  pass in progress.
- done  out  1  single-cycle pulse at the end of a pass.
- mem_req_valid  out  1  tile entry read request.
- mem_req_addr  out  32  byte address of the entry.
- mem_req_ready  in  1  request accepted.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  64  entry: [15:0] tile_x, [31:16] tile_y, [63:32] prim_count.
- mem_rsp_ready  out  1  response accepted.
- slice_valid  out  NUM_SLICES  one-hot tile offer.
- slice_tile_x, slice_tile_y  out  16 each  tile position, shared by all slices.
- slice_prim_count  out  32  primitives in the tile.
- slice_pbuf_addr, slice_pbuf_stride  out  32 each  copies of the latched DCRs.
- slice_ready  in  NUM_SLICES  slice can accept a tile.

## Operation
- DCR registers reset to 0: tbuf_addr, tile_count, pbuf_addr, pbuf_stride.
  - They load on `dcr_write_valid` at DCR_RASTER_TBUF_ADDR, TILE_COUNT, PBUF_ADDR and PBUF_STRIDE.
  - Other addresses, including DST_SIZE, are ignored.
  - Writes are dropped while `busy`=1.
- FSM has states IDLE, FETCH, WAIT_RSP, DISPATCH and DONE. It resets to IDLE.
  - IDLE: on `start`, set idx=0. Go to DONE if tile_count==0, otherwise go to FETCH.
  - FETCH: `mem_req_valid`=1 and `mem_req_addr`=tbuf_addr+idx*8, with 32-bit wrap. On `mem_req_ready`, go to WAIT_RSP.
  - WAIT_RSP: `mem_rsp_ready`=1. On `mem_rsp_valid`, register the entry. Go to DISPATCH, or skip the entry (see Configuration).
  - DISPATCH: grant = first set bit of `slice_ready` searching from rr_ptr upward, wrapping. `slice_valid`=grant, so it depends combinationally on `slice_ready`.
    - A handshake happens on any set grant bit. On a handshake, rr_ptr = granted index+1 mod NUM_SLICES and idx++.
    - Next state is DONE if idx was tile_count-1, otherwise FETCH.
    - If no slice is ready, stay in DISPATCH.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy` = state!=IDLE. A `start` while busy is ignored. rr_ptr resets to 0 and persists across passes.
- Only one memory request is outstanding at a time. Responses outside WAIT_RSP cannot occur and are ignored.
- Reset asserted mid-pass: all state clears immediately and no `done` is produced.

## Timing
- Output reset values: `busy`, `done`, `mem_req_valid`, `mem_rsp_ready` and `slice_valid` are 0. All data outputs are 0.
- Data outputs come from registers, except `slice_valid`, which is combinational from state, rr_ptr and `slice_ready`.
- `start` at cycle 0 puts FETCH and `mem_req_valid` in cycle 1.
- A response accepted in cycle N gives `slice_valid` in cycle N+1, when a slice is ready.
- A handshake in cycle M gives the next `mem_req_valid` in cycle M+1.
- Per-tile minimum is 3 cycles + memory latency.
- `done` comes 1 cycle after the last handshake or skip.

## Configuration
- Macro: RASTER_SKIP_EMPTY_EN.
- Defined: an entry with prim_count==0 is not dispatched. WAIT_RSP increments idx and goes to FETCH, or to DONE if it was the last entry.
- Undefined: every entry is dispatched, including prim_count==0.

## Test plan
- Reset with pins driven: all outputs 0, `busy`=0. DCR write of TBUF_ADDR=0x1000, then read back via a pass: first `mem_req_addr`=0x1000.
- tile_count=3, all slices ready, 0-cycle memory: addresses 0x1000, 0x1008, 0x1010. Grants go to slices 0, 1, 2. One `done` pulse.
- `slice_ready`=4'b0100 with rr_ptr=0: grant is slice 2 and rr_ptr becomes 3. Then `slice_ready`=0 for 10 cycles: stays in DISPATCH with no handshake.
- tile_count=0, `start`: `done` on the next cycle and no memory request.
- Empty tile, entry 1 of 3 has prim_count=0: with the macro, 2 dispatches; without it, 3.
- Mid-pass events: a DCR write and a second `start` while busy have no effect. Asserting reset in WAIT_RSP returns to IDLE with no `done`.
